i_sensor_read: RTL and testbench

Configuration and timing controller for the LUPA300 image sensor.

- After reset, it holds the sensor in reset, then releases it and uploads a fixed register table over a 3-wire SPI link.
- It then enters streaming mode and generates slave-mode integration pulses (INT_TIME1..3) frame after frame, gated by a host-ready input.
- It sits between the system clock manager (80 MHz) and the sensor pads; pixel capture into the FIFO is done outside this block.

---
 rtl/i_sensor_read.sv | 186 ++++++++++++++++++
 tb/tb_i_sensor_read.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/i_sensor_read.sv
// LUPA300 controller: power-up reset, SPI register upload, then slave-mode integration pulses.
// All outputs are flops; the frame timer pauses in readout while synchronized Frame_Valid is high.
module i_sensor_read #(
  parameter int                     CLK_DIV       = 4,
  parameter int                     RST_CYCLES    = 1000,
  parameter int                     SETTLE_CYCLES = 1000,
  parameter int                     NUM_REGS      = 4,
  parameter logic [16*NUM_REGS-1:0] CFG_WORDS     = 64'h1A05_0C40_0681_0203,
  parameter int                     INT_CYCLES    = 40000,
  parameter int                     FRAME_CYCLES  = 400000
) (
  input  logic       iCLOCK_80,
  input  logic       rst,
  output logic       SPI_EN,
  output logic       SPI_CLK,
  output logic       SPI_DAT,
  input  logic       Line_Valid,
  input  logic       Frame_Valid,
  output logic       INT_TIME1,
  output logic       INT_TIME2,
  output logic       INT_TIME3,
  output logic       RST_N,
  input  logic       Qt_ins,
  output logic [3:0] debug
);
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [3:0] {
    S_RST    = 4'b0001,
    S_SETTLE = 4'b0010,
    S_SPI    = 4'b0100,
    S_GAP    = 4'b1000,
    S_STREAM = 4'b1111
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [15:0]   sreg_q, sreg_d;
  logic [19:0]   fc_q, fc_d;
  logic          spi_en_q, spi_en_d;
  logic          spi_clk_q, spi_clk_d;
  logic          spi_dat_q, spi_dat_d;
  logic          rst_n_q, rst_n_d;
  logic          int1_q, int1_d;
  logic [1:0]    fv_sync_q, fv_sync_d;
  logic [1:0]    lv_sync_unused_q, lv_sync_unused_d;
  logic [IW-1:0] nxt_idx;
  logic [15:0]   nxt_word;

  assign nxt_idx  = idx_q + IW'(1);
  assign nxt_word = CFG_WORDS[{nxt_idx, 4'b0000} +: 16];

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    bit_d            = bit_q;
    idx_d            = idx_q;
    sreg_d           = sreg_q;
    fc_d             = 20'd0;
    spi_en_d         = spi_en_q;
    spi_clk_d        = spi_clk_q;
    spi_dat_d        = spi_dat_q;
    rst_n_d          = rst_n_q;
    int1_d           = 1'b0;
    fv_sync_d        = {fv_sync_q[0], Frame_Valid};
    lv_sync_unused_d = {lv_sync_unused_q[0], Line_Valid};

    case (state_q)
      S_RST: begin
        rst_n_d = 1'b0;
        cnt_d   = cnt_q + 32'd1;
        if (cnt_q == 32'(RST_CYCLES - 1)) begin
          state_d = S_SETTLE;
          rst_n_d = 1'b1;
          cnt_d   = 32'd0;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == 32'(SETTLE_CYCLES - 1)) begin
          state_d   = S_SPI;
          cnt_d     = 32'd0;
          bit_d     = 4'd0;
          idx_d     = '0;
          sreg_d    = CFG_WORDS[15:0];
          spi_en_d  = 1'b1;
          spi_clk_d = 1'b0;
          spi_dat_d = CFG_WORDS[15];
        end
      end
      S_SPI: begin
        // cnt_q is the phase within the current bit; sreg_q[15] is the bit on the pin
        if (cnt_q == 32'(CLK_DIV - 1)) begin
          cnt_d     = 32'd0;
          spi_clk_d = 1'b0;
          if (bit_q == 4'd15) begin
            state_d   = S_GAP;
            spi_en_d  = 1'b0;
            spi_dat_d = 1'b0;
          end else begin
            bit_d     = bit_q + 4'd1;
            sreg_d    = {sreg_q[14:0], 1'b0};
            spi_dat_d = sreg_q[14];
          end
        end else begin
          cnt_d     = cnt_q + 32'd1;
          spi_clk_d = ((cnt_q + 32'd1) >= 32'(CLK_DIV / 2));
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == 32'(4 * CLK_DIV - 1)) begin
          cnt_d = 32'd0;
          if (idx_q == IW'(NUM_REGS - 1)) begin
            state_d = S_STREAM;
          end else begin
            state_d   = S_SPI;
            idx_d     = nxt_idx;
            bit_d     = 4'd0;
            sreg_d    = nxt_word;
            spi_en_d  = 1'b1;
            spi_dat_d = nxt_word[15];
          end
        end
      end
      S_STREAM: begin
        if (Qt_ins) begin
          int1_d = (fc_q < 20'(INT_CYCLES));
          // Frame end stalls while the sensor is still reading out
          if (fc_q == 20'(FRAME_CYCLES - 1)) begin
            fc_d = fv_sync_q[1] ? fc_q : 20'd0;
          end else begin
            fc_d = fc_q + 20'd1;
          end
        end
      end
      default: begin
        state_d = S_RST;
      end
    endcase
  end

  always_ff @(posedge iCLOCK_80 or posedge rst) begin
    if (rst) begin
      state_q          <= S_RST;
      cnt_q            <= 32'd0;
      bit_q            <= 4'd0;
      idx_q            <= '0;
      sreg_q           <= 16'd0;
      fc_q             <= 20'd0;
      spi_en_q         <= 1'b0;
      spi_clk_q        <= 1'b0;
      spi_dat_q        <= 1'b0;
      rst_n_q          <= 1'b0;
      int1_q           <= 1'b0;
      fv_sync_q        <= 2'b00;
      lv_sync_unused_q <= 2'b00;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      bit_q            <= bit_d;
      idx_q            <= idx_d;
      sreg_q           <= sreg_d;
      fc_q             <= fc_d;
      spi_en_q         <= spi_en_d;
      spi_clk_q        <= spi_clk_d;
      spi_dat_q        <= spi_dat_d;
      rst_n_q          <= rst_n_d;
      int1_q           <= int1_d;
      fv_sync_q        <= fv_sync_d;
      lv_sync_unused_q <= lv_sync_unused_d;
    end
  end

  assign SPI_EN    = spi_en_q;
  assign SPI_CLK   = spi_clk_q;
  assign SPI_DAT   = spi_dat_q;
  assign RST_N     = rst_n_q;
  assign INT_TIME1 = int1_q;
  assign INT_TIME2 = 1'b0;
  assign INT_TIME3 = 1'b0;
  assign debug     = state_q;

endmodule

// File: tb/tb_i_sensor_read.sv
// Directed bench for i_sensor_read: reset sequencing, SPI upload, frame timer, abort by reset.
module tb_i_sensor_read;
  localparam int CLK_DIV       = 4;
  localparam int RST_CYCLES    = 10;
  localparam int SETTLE_CYCLES = 5;
  localparam int NUM_REGS      = 4;
  localparam int INT_CYCLES    = 8;
  localparam int FRAME_CYCLES  = 20;

  logic       iCLOCK_80   = 1'b0;
  logic       rst         = 1'b1;
  logic       Line_Valid  = 1'b0;
  logic       Frame_Valid = 1'b0;
  logic       Qt_ins      = 1'b1;
  logic       SPI_EN, SPI_CLK, SPI_DAT;
  logic       INT_TIME1, INT_TIME2, INT_TIME3, RST_N;
  logic [3:0] debug;

  int checks = 0;
  int passed = 0;

  logic [15:0] exp_words [4] = '{16'h0203, 16'h0681, 16'h0C40, 16'h1A05};

  typedef struct {
    logic qt;
    logic fv;
    logic exp_int;
  } vec_t;
  vec_t vecs[$];

  always #5 iCLOCK_80 = ~iCLOCK_80;

  i_sensor_read #(
    .CLK_DIV      (CLK_DIV),
    .RST_CYCLES   (RST_CYCLES),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .NUM_REGS     (NUM_REGS),
    .CFG_WORDS    (64'h1A05_0C40_0681_0203),
    .INT_CYCLES   (INT_CYCLES),
    .FRAME_CYCLES (FRAME_CYCLES)
  ) dut (
    .iCLOCK_80  (iCLOCK_80),
    .rst        (rst),
    .SPI_EN     (SPI_EN),
    .SPI_CLK    (SPI_CLK),
    .SPI_DAT    (SPI_DAT),
    .Line_Valid (Line_Valid),
    .Frame_Valid(Frame_Valid),
    .INT_TIME1  (INT_TIME1),
    .INT_TIME2  (INT_TIME2),
    .INT_TIME3  (INT_TIME3),
    .RST_N      (RST_N),
    .Qt_ins     (Qt_ins),
    .debug      (debug)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic add_seg(input int n, input logic qt, input logic fv, input logic e);
    vec_t v;
    v.qt = qt;
    v.fv = fv;
    v.exp_int = e;
    repeat (n) vecs.push_back(v);
  endtask

  // Leaves the bench on the sample where SPI_EN is first seen high.
  task automatic reset_sequence();
    rst = 1'b1;
    repeat (3) @(negedge iCLOCK_80);
    check("rst_debug", 32'(debug), 32'h1);
    check("rst_rst_n", 32'(RST_N), 32'h0);
    check("rst_spi", 32'({SPI_EN, SPI_CLK, SPI_DAT}), 32'h0);
    check("rst_int", 32'({INT_TIME1, INT_TIME2, INT_TIME3}), 32'h0);
    rst = 1'b0;
    for (int k = 1; k <= RST_CYCLES + SETTLE_CYCLES; k++) begin
      @(negedge iCLOCK_80);
      check($sformatf("seq_rst_n_k%0d", k), 32'(RST_N), (k >= RST_CYCLES) ? 32'h1 : 32'h0);
      check($sformatf("seq_spi_en_k%0d", k), 32'(SPI_EN),
            (k == RST_CYCLES + SETTLE_CYCLES) ? 32'h1 : 32'h0);
      check($sformatf("seq_debug_k%0d", k), 32'(debug),
            (k < RST_CYCLES) ? 32'h1 : (k < RST_CYCLES + SETTLE_CYCLES) ? 32'h2 : 32'h4);
    end
  endtask

  // Entered on the first SPI_EN-high sample of word w; exits on the next word's first
  // high sample, or on the first S_STREAM sample after the last word.
  task automatic capture_word(input int w);
    logic [15:0] sh;
    logic        prev_clk;
    logic        gap_bad;
    logic        int_bad;
    int          hi;
    int          lo;
    sh = 16'h0; prev_clk = 1'b0; gap_bad = 1'b0; int_bad = 1'b0; hi = 0; lo = 0;
    while (SPI_EN === 1'b1 && hi < 100) begin
      if (SPI_CLK === 1'b1 && prev_clk === 1'b0) sh = {sh[14:0], SPI_DAT};
      if (INT_TIME1 !== 1'b0 || RST_N !== 1'b1) int_bad = 1'b1;
      prev_clk = SPI_CLK;
      hi++;
      @(negedge iCLOCK_80);
    end
    check($sformatf("spi_word%0d", w), 32'(sh), 32'(exp_words[w]));
    check($sformatf("spi_en_len%0d", w), hi, 16 * CLK_DIV);
    while (SPI_EN !== 1'b1 && debug !== 4'b1111 && lo < 100) begin
      if (SPI_CLK !== 1'b0 || SPI_DAT !== 1'b0 || debug !== 4'b1000) gap_bad = 1'b1;
      if (INT_TIME1 !== 1'b0 || RST_N !== 1'b1) int_bad = 1'b1;
      lo++;
      @(negedge iCLOCK_80);
    end
    check($sformatf("spi_gap_len%0d", w), lo, 4 * CLK_DIV);
    check($sformatf("spi_gap_idle%0d", w), 32'(gap_bad), 32'h0);
    check($sformatf("int_rst_n_pre_stream%0d", w), 32'(int_bad), 32'h0);
    if (w == NUM_REGS - 1) begin
      check("debug_stream", 32'(debug), 32'hF);
      check("int_on_stream_entry", 32'(INT_TIME1), 32'h0);
    end else begin
      check($sformatf("next_word_en%0d", w), 32'(SPI_EN), 32'h1);
    end
  endtask

  initial begin
    // Vector i: inputs driven before clock edge i, INT_TIME1 expected after that edge.
    add_seg(8, 1'b1, 1'b0, 1'b1);   // 1-8: first pulse
    add_seg(12, 1'b1, 1'b0, 1'b0);  // 9-20
    add_seg(8, 1'b1, 1'b0, 1'b1);   // 21-28
    add_seg(12, 1'b1, 1'b0, 1'b0);  // 29-40
    add_seg(8, 1'b1, 1'b0, 1'b1);   // 41-48
    add_seg(6, 1'b1, 1'b0, 1'b0);   // 49-54
    add_seg(15, 1'b1, 1'b1, 1'b0);  // 55-69: readout spans the frame end at edge 60
    add_seg(3, 1'b1, 1'b0, 1'b0);   // 70-72: synchronizer drains, fc wraps at 72
    add_seg(8, 1'b1, 1'b0, 1'b1);   // 73-80
    add_seg(12, 1'b1, 1'b0, 1'b0);  // 81-92
    add_seg(3, 1'b1, 1'b0, 1'b1);   // 93-95: pulse starts
    add_seg(4, 1'b0, 1'b0, 1'b0);   // 96-99: host drops ready mid-pulse
    add_seg(8, 1'b1, 1'b0, 1'b1);   // 100-107: full pulse from fc=0
    add_seg(12, 1'b1, 1'b0, 1'b0);  // 108-119
    add_seg(1, 1'b1, 1'b0, 1'b1);   // 120

    reset_sequence();
    for (int w = 0; w < NUM_REGS; w++) capture_word(w);

    foreach (vecs[i]) begin
      Qt_ins      = vecs[i].qt;
      Frame_Valid = vecs[i].fv;
      Line_Valid  = ~Line_Valid;
      @(negedge iCLOCK_80);
      check($sformatf("int1_v%0d", i + 1), 32'(INT_TIME1), 32'(vecs[i].exp_int));
      check($sformatf("stream_static_v%0d", i + 1), 32'({INT_TIME2, INT_TIME3, debug}), 32'h0F);
    end

    // Abort during word 2 while SPI_CLK and SPI_DAT are both high (bit 4 of 16'h0C40).
    reset_sequence();
    capture_word(0);
    capture_word(1);
    repeat (4 * CLK_DIV + CLK_DIV / 2) @(negedge iCLOCK_80);
    check("pre_abort_pins", 32'({SPI_EN, SPI_CLK, SPI_DAT, RST_N}), 32'hF);
    check("pre_abort_debug", 32'(debug), 32'h4);
    rst = 1'b1;
    #1;
    check("abort_pins", 32'({SPI_EN, SPI_CLK, SPI_DAT, RST_N}), 32'h0);
    check("abort_debug", 32'(debug), 32'h1);
    check("abort_int", 32'(INT_TIME1), 32'h0);
    reset_sequence();
    capture_word(0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

endmodule
